// File: rtl/l1_l2_request_port.sv
// L1 -> L2 request port: round-robin arbitration of store-buffer and load-miss dequeues into a
// one-entry request register, plus a registered decoder for L2 responses. Optional: L1_L2_REQ_PERF_EN.
module l1_l2_request_port #(
    parameter int LINE_BYTES    = 64,
    parameter int ADDR_WIDTH    = 32,
    parameter int IDX_WIDTH     = 2,
    parameter int CORE_ID_WIDTH = 2,
    parameter int CORE_ID       = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sb_dequeue_ready,
    input  logic [ADDR_WIDTH-1:0]      sb_dequeue_addr,
    input  logic [IDX_WIDTH-1:0]       sb_dequeue_idx,
    input  logic [LINE_BYTES-1:0]      sb_dequeue_mask,
    input  logic [LINE_BYTES*8-1:0]    sb_dequeue_data,
    input  logic                       sb_dequeue_synchronized,
    output logic                       sb_dequeue_ack,
    input  logic                       lm_dequeue_ready,
    input  logic [ADDR_WIDTH-1:0]      lm_dequeue_addr,
    input  logic [IDX_WIDTH-1:0]       lm_dequeue_idx,
    input  logic                       lm_dequeue_synchronized,
    output logic                       lm_dequeue_ack,
    output logic                       l2_req_valid,
    input  logic                       l2_req_ready,
    output logic [1:0]                 l2_req_op,
    output logic [CORE_ID_WIDTH-1:0]   l2_req_core,
    output logic [IDX_WIDTH-1:0]       l2_req_id,
    output logic [ADDR_WIDTH-1:0]      l2_req_addr,
    output logic [LINE_BYTES-1:0]      l2_req_mask,
    output logic [LINE_BYTES*8-1:0]    l2_req_data,
    input  logic                       l2_rsp_valid,
    input  logic [CORE_ID_WIDTH-1:0]   l2_rsp_core,
    input  logic [1:0]                 l2_rsp_op,
    input  logic [IDX_WIDTH-1:0]       l2_rsp_id,
    input  logic                       l2_rsp_status,
    input  logic [LINE_BYTES*8-1:0]    l2_rsp_data,
    output logic                       storebuf_l2_response_valid,
    output logic [IDX_WIDTH-1:0]       storebuf_l2_response_idx,
    output logic                       storebuf_l2_sync_success,
    output logic                       fill_valid,
    output logic [IDX_WIDTH-1:0]       fill_idx,
    output logic                       fill_sync,
    output logic [LINE_BYTES*8-1:0]    fill_data
`ifdef L1_L2_REQ_PERF_EN
    ,
    output logic [31:0]                perf_stall_cycles,
    output logic [31:0]                perf_store_reqs
`endif
);

    localparam logic [CORE_ID_WIDTH-1:0] CORE_ID_L     = CORE_ID_WIDTH'(CORE_ID);
    localparam logic [1:0]               OP_STORE_SYNC = 2'd3;

    // Handshakes: a source holds *_dequeue_ready (and its fields) until it sees *_dequeue_ack,
    // which is combinational in the same cycle; l2_req_* transfers on l2_req_valid && l2_req_ready.
    logic can_accept;
    logic grant_sb;
    logic grant_lm;
    logic last_store;   // last grant went to the store buffer; reset value favours store

    always_comb begin
        can_accept = !l2_req_valid || l2_req_ready;
        grant_sb   = can_accept && sb_dequeue_ready && (!lm_dequeue_ready || !last_store);
        grant_lm   = can_accept && lm_dequeue_ready && !grant_sb;
    end

    assign sb_dequeue_ack = grant_sb;
    assign lm_dequeue_ack = grant_lm;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_store   <= 1'b0;
            l2_req_valid <= 1'b0;
            l2_req_op    <= 2'd0;
            l2_req_core  <= '0;
            l2_req_id    <= '0;
            l2_req_addr  <= '0;
            l2_req_mask  <= '0;
            l2_req_data  <= '0;
        end else begin
            if (grant_sb) begin
                last_store   <= 1'b1;
                l2_req_valid <= 1'b1;
                l2_req_op    <= {sb_dequeue_synchronized, 1'b1};
                l2_req_core  <= CORE_ID_L;
                l2_req_id    <= sb_dequeue_idx;
                l2_req_addr  <= sb_dequeue_addr;
                l2_req_mask  <= sb_dequeue_mask;
                l2_req_data  <= sb_dequeue_data;
            end else if (grant_lm) begin
                last_store   <= 1'b0;
                l2_req_valid <= 1'b1;
                l2_req_op    <= {lm_dequeue_synchronized, 1'b0};
                l2_req_core  <= CORE_ID_L;
                l2_req_id    <= lm_dequeue_idx;
                l2_req_addr  <= lm_dequeue_addr;
                l2_req_mask  <= '1;
                l2_req_data  <= '0;
            end else if (l2_req_ready) begin
                l2_req_valid <= 1'b0;
            end
        end
    end

    // Response decode: op[0] distinguishes store completions from load fills.
    logic rsp_hit;
    assign rsp_hit = l2_rsp_valid && (l2_rsp_core == CORE_ID_L);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            storebuf_l2_response_valid <= 1'b0;
            storebuf_l2_response_idx   <= '0;
            storebuf_l2_sync_success   <= 1'b0;
            fill_valid                 <= 1'b0;
            fill_idx                   <= '0;
            fill_sync                  <= 1'b0;
            fill_data                  <= '0;
        end else begin
            storebuf_l2_response_valid <= rsp_hit && l2_rsp_op[0];
            fill_valid                 <= rsp_hit && !l2_rsp_op[0];
            if (rsp_hit && l2_rsp_op[0]) begin
                storebuf_l2_response_idx <= l2_rsp_id;
                storebuf_l2_sync_success <= (l2_rsp_op == OP_STORE_SYNC) && l2_rsp_status;
            end
            if (rsp_hit && !l2_rsp_op[0]) begin
                fill_idx  <= l2_rsp_id;
                fill_sync <= l2_rsp_op[1];
                fill_data <= l2_rsp_data;
            end
        end
    end

`ifdef L1_L2_REQ_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_cycles <= 32'd0;
            perf_store_reqs   <= 32'd0;
        end else begin
            if (l2_req_valid && !l2_req_ready) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (grant_sb) begin
                perf_store_reqs <= perf_store_reqs + 32'd1;
            end
        end
    end
`endif

    sb_ready_held_until_ack: assert property (@(posedge clk) disable iff (!reset_n)
        (sb_dequeue_ready && !sb_dequeue_ack) |=> sb_dequeue_ready);

    lm_ready_held_until_ack: assert property (@(posedge clk) disable iff (!reset_n)
        (lm_dequeue_ready && !lm_dequeue_ack) |=> lm_dequeue_ready);

endmodule

// File: tb/tb_l1_l2_request_port.sv
// Bench for l1_l2_request_port: directed scenarios plus a randomized run checked against
// a packet-queue reference model.
module tb_l1_l2_request_port;
    localparam int LINE_BYTES    = 64;
    localparam int ADDR_WIDTH    = 32;
    localparam int IDX_WIDTH     = 2;
    localparam int CORE_ID_WIDTH = 2;
    localparam int CORE_ID       = 0;
    localparam int DW            = LINE_BYTES * 8;
    localparam int PW            = 2 + CORE_ID_WIDTH + IDX_WIDTH + ADDR_WIDTH + LINE_BYTES + DW;
    localparam logic [CORE_ID_WIDTH-1:0] CORE_ID_V = CORE_ID_WIDTH'(CORE_ID);

    // clock / reset
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic                     sb_dequeue_ready, sb_dequeue_synchronized, sb_dequeue_ack;
    logic [ADDR_WIDTH-1:0]    sb_dequeue_addr;
    logic [IDX_WIDTH-1:0]     sb_dequeue_idx;
    logic [LINE_BYTES-1:0]    sb_dequeue_mask;
    logic [DW-1:0]            sb_dequeue_data;
    logic                     lm_dequeue_ready, lm_dequeue_synchronized, lm_dequeue_ack;
    logic [ADDR_WIDTH-1:0]    lm_dequeue_addr;
    logic [IDX_WIDTH-1:0]     lm_dequeue_idx;
    logic                     l2_req_valid, l2_req_ready;
    logic [1:0]               l2_req_op;
    logic [CORE_ID_WIDTH-1:0] l2_req_core;
    logic [IDX_WIDTH-1:0]     l2_req_id;
    logic [ADDR_WIDTH-1:0]    l2_req_addr;
    logic [LINE_BYTES-1:0]    l2_req_mask;
    logic [DW-1:0]            l2_req_data;
    logic                     l2_rsp_valid, l2_rsp_status;
    logic [CORE_ID_WIDTH-1:0] l2_rsp_core;
    logic [1:0]               l2_rsp_op;
    logic [IDX_WIDTH-1:0]     l2_rsp_id;
    logic [DW-1:0]            l2_rsp_data;
    logic                     storebuf_l2_response_valid, storebuf_l2_sync_success;
    logic [IDX_WIDTH-1:0]     storebuf_l2_response_idx;
    logic                     fill_valid, fill_sync;
    logic [IDX_WIDTH-1:0]     fill_idx;
    logic [DW-1:0]            fill_data;
`ifdef L1_L2_REQ_PERF_EN
    logic [31:0]              perf_stall_cycles, perf_store_reqs;
`endif

    l1_l2_request_port #(
        .LINE_BYTES(LINE_BYTES), .ADDR_WIDTH(ADDR_WIDTH), .IDX_WIDTH(IDX_WIDTH),
        .CORE_ID_WIDTH(CORE_ID_WIDTH), .CORE_ID(CORE_ID)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .sb_dequeue_ready(sb_dequeue_ready), .sb_dequeue_addr(sb_dequeue_addr),
        .sb_dequeue_idx(sb_dequeue_idx), .sb_dequeue_mask(sb_dequeue_mask),
        .sb_dequeue_data(sb_dequeue_data), .sb_dequeue_synchronized(sb_dequeue_synchronized),
        .sb_dequeue_ack(sb_dequeue_ack),
        .lm_dequeue_ready(lm_dequeue_ready), .lm_dequeue_addr(lm_dequeue_addr),
        .lm_dequeue_idx(lm_dequeue_idx), .lm_dequeue_synchronized(lm_dequeue_synchronized),
        .lm_dequeue_ack(lm_dequeue_ack),
        .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready), .l2_req_op(l2_req_op),
        .l2_req_core(l2_req_core), .l2_req_id(l2_req_id), .l2_req_addr(l2_req_addr),
        .l2_req_mask(l2_req_mask), .l2_req_data(l2_req_data),
        .l2_rsp_valid(l2_rsp_valid), .l2_rsp_core(l2_rsp_core), .l2_rsp_op(l2_rsp_op),
        .l2_rsp_id(l2_rsp_id), .l2_rsp_status(l2_rsp_status), .l2_rsp_data(l2_rsp_data),
        .storebuf_l2_response_valid(storebuf_l2_response_valid),
        .storebuf_l2_response_idx(storebuf_l2_response_idx),
        .storebuf_l2_sync_success(storebuf_l2_sync_success),
        .fill_valid(fill_valid), .fill_idx(fill_idx), .fill_sync(fill_sync), .fill_data(fill_data)
`ifdef L1_L2_REQ_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_store_reqs(perf_store_reqs)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: packets granted but not yet taken by the interconnect, the last
    // granted source, and the expected response-side outputs.
    logic [PW-1:0] exp_q[$];
    logic          m_last_store;
    logic          e_sb_ack, e_lm_ack;
    logic          m_sbv, m_sbss, m_fv, m_fsync;
    logic [IDX_WIDTH-1:0] m_sbidx, m_fidx;
    logic [DW-1:0] m_fdata;

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [LINE_BYTES-1:0] rand_mask();
        return {$urandom, $urandom};
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_last_store = 1'b0;
        m_sbv = 1'b0; m_sbss = 1'b0; m_sbidx = '0;
        m_fv = 1'b0; m_fsync = 1'b0; m_fidx = '0; m_fdata = '0;
    endtask

    task automatic model_grant();
        logic can;
        can = (exp_q.size() == 0) || l2_req_ready;
        e_sb_ack = 1'b0;
        e_lm_ack = 1'b0;
        if (can) begin
            if (sb_dequeue_ready && lm_dequeue_ready) begin
                if (m_last_store) e_lm_ack = 1'b1;
                else e_sb_ack = 1'b1;
            end else if (sb_dequeue_ready) begin
                e_sb_ack = 1'b1;
            end else if (lm_dequeue_ready) begin
                e_lm_ack = 1'b1;
            end
        end
    endtask

    task automatic zero_inputs();
        sb_dequeue_ready = 0; sb_dequeue_addr = '0; sb_dequeue_idx = '0; sb_dequeue_mask = '0;
        sb_dequeue_data = '0; sb_dequeue_synchronized = 0;
        lm_dequeue_ready = 0; lm_dequeue_addr = '0; lm_dequeue_idx = '0; lm_dequeue_synchronized = 0;
        l2_req_ready = 0;
        l2_rsp_valid = 0; l2_rsp_core = '0; l2_rsp_op = '0; l2_rsp_id = '0; l2_rsp_status = 0;
        l2_rsp_data = '0;
    endtask

    // driver tasks
    task automatic settle();
        #1;
        model_grant();
    endtask

    task automatic tick();
        model_grant();
        if (exp_q.size() != 0 && l2_req_ready) void'(exp_q.pop_front());
        if (e_sb_ack) begin
            exp_q.push_back({sb_dequeue_synchronized, 1'b1, CORE_ID_V, sb_dequeue_idx,
                             sb_dequeue_addr, sb_dequeue_mask, sb_dequeue_data});
            m_last_store = 1'b1;
        end else if (e_lm_ack) begin
            exp_q.push_back({lm_dequeue_synchronized, 1'b0, CORE_ID_V, lm_dequeue_idx,
                             lm_dequeue_addr, {LINE_BYTES{1'b1}}, {DW{1'b0}}});
            m_last_store = 1'b0;
        end
        m_sbv = 1'b0;
        m_fv = 1'b0;
        if (l2_rsp_valid && l2_rsp_core == CORE_ID_V) begin
            case (l2_rsp_op)
                2'd0, 2'd2: begin
                    m_fv = 1'b1; m_fidx = l2_rsp_id; m_fsync = (l2_rsp_op == 2'd2);
                    m_fdata = l2_rsp_data;
                end
                2'd1: begin m_sbv = 1'b1; m_sbidx = l2_rsp_id; m_sbss = 1'b0; end
                default: begin m_sbv = 1'b1; m_sbidx = l2_rsp_id; m_sbss = l2_rsp_status; end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        settle();
        checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", l2_req_valid); end
        checks++; if ({l2_req_op, l2_req_id, l2_req_addr, l2_req_mask} !== '0) begin failures++; $display("FAIL reset_fields got=%h exp=0", {l2_req_op, l2_req_id, l2_req_addr, l2_req_mask}); end
        checks++; if (l2_req_data !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", l2_req_data); end
        checks++; if ({storebuf_l2_response_valid, storebuf_l2_sync_success, fill_valid, fill_sync} !== 4'b0) begin failures++; $display("FAIL reset_rsp got=%b exp=0000", {storebuf_l2_response_valid, storebuf_l2_sync_success, fill_valid, fill_sync}); end
        checks++; if (fill_data !== '0) begin failures++; $display("FAIL reset_fill_data got=%h exp=0", fill_data); end
        checks++; if ({sb_dequeue_ack, lm_dequeue_ack} !== 2'b00) begin failures++; $display("FAIL reset_acks got=%b exp=00", {sb_dequeue_ack, lm_dequeue_ack}); end
    endtask

    task automatic test_store_only();
        do_reset();
        sb_dequeue_ready = 1; sb_dequeue_addr = 32'h1000; sb_dequeue_idx = 2'd2;
        sb_dequeue_mask = 64'hF; sb_dequeue_data = rand_line(); l2_req_ready = 1;
        settle();
        checks++; if ({sb_dequeue_ack, lm_dequeue_ack} !== 2'b10) begin failures++; $display("FAIL store_ack got=%b exp=10", {sb_dequeue_ack, lm_dequeue_ack}); end
        tick();
        sb_dequeue_ready = 0;
        checks++; if (l2_req_valid !== 1'b1) begin failures++; $display("FAIL store_valid got=%b exp=1", l2_req_valid); end
        checks++; if ({l2_req_op, l2_req_id, l2_req_addr, l2_req_mask} !== {2'd1, 2'd2, 32'h1000, 64'hF}) begin failures++; $display("FAIL store_fields got=%h exp=%h", {l2_req_op, l2_req_id, l2_req_addr, l2_req_mask}, {2'd1, 2'd2, 32'h1000, 64'hF}); end
        checks++; if (l2_req_data !== sb_dequeue_data) begin failures++; $display("FAIL store_data got=%h exp=%h", l2_req_data, sb_dequeue_data); end
        settle();
        tick();
        checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL store_valid_drop got=%b exp=0", l2_req_valid); end
    endtask

    task automatic test_back_to_back();
        logic exp_store;
        do_reset();
        l2_req_ready = 1;
        for (int i = 0; i < 8; i++) begin
            sb_dequeue_ready = 1; sb_dequeue_addr = $urandom; sb_dequeue_idx = 2'($urandom);
            sb_dequeue_mask = rand_mask(); sb_dequeue_data = rand_line();
            sb_dequeue_synchronized = 1'($urandom);
            lm_dequeue_ready = 1; lm_dequeue_addr = $urandom; lm_dequeue_idx = 2'($urandom);
            lm_dequeue_synchronized = 1'($urandom);
            settle();
            exp_store = (i % 2 == 0);
            checks++; if ({sb_dequeue_ack, lm_dequeue_ack} !== {exp_store, !exp_store}) begin failures++; $display("FAIL b2b_ack i=%0d got=%b exp=%b", i, {sb_dequeue_ack, lm_dequeue_ack}, {exp_store, !exp_store}); end
            tick();
            checks++; if (l2_req_valid !== 1'b1 || exp_q.size() == 0 || {l2_req_op, l2_req_core, l2_req_id, l2_req_addr, l2_req_mask, l2_req_data} !== exp_q[0]) begin failures++; $display("FAIL b2b_pkt i=%0d valid=%b op=%0d id=%0d addr=%h", i, l2_req_valid, l2_req_op, l2_req_id, l2_req_addr); end
            if (!exp_store) begin
                checks++; if (l2_req_mask !== {LINE_BYTES{1'b1}} || l2_req_data !== '0 || l2_req_op[0] !== 1'b0) begin failures++; $display("FAIL b2b_load_fill i=%0d got_mask=%h exp_mask=all-ones got_op=%0d", i, l2_req_mask, l2_req_op); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [ADDR_WIDTH-1:0] a_addr;
        logic [IDX_WIDTH-1:0]  a_idx;
        logic [DW-1:0]         a_data;
        do_reset();
        a_addr = 32'h0000_2040; a_idx = 2'd1; a_data = rand_line();
        sb_dequeue_ready = 1; sb_dequeue_addr = a_addr; sb_dequeue_idx = a_idx;
        sb_dequeue_mask = 64'hFF00; sb_dequeue_data = a_data; l2_req_ready = 0;
        settle();
        checks++; if (sb_dequeue_ack !== 1'b1) begin failures++; $display("FAIL bp_first_ack got=%b exp=1", sb_dequeue_ack); end
        tick();
        sb_dequeue_addr = 32'h0000_3080; sb_dequeue_idx = 2'd3; sb_dequeue_mask = 64'h1;
        sb_dequeue_data = rand_line(); sb_dequeue_synchronized = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (sb_dequeue_ack !== 1'b0) begin failures++; $display("FAIL bp_no_ack i=%0d got=%b exp=0", i, sb_dequeue_ack); end
            tick();
            checks++; if ({l2_req_valid, l2_req_op, l2_req_id, l2_req_addr, l2_req_mask, l2_req_data} !== {1'b1, 2'd1, a_idx, a_addr, 64'hFF00, a_data}) begin failures++; $display("FAIL bp_hold i=%0d valid=%b op=%0d id=%0d addr=%h exp_addr=%h", i, l2_req_valid, l2_req_op, l2_req_id, l2_req_addr, a_addr); end
        end
        l2_req_ready = 1;
        settle();
        checks++; if (sb_dequeue_ack !== 1'b1) begin failures++; $display("FAIL bp_release_ack got=%b exp=1", sb_dequeue_ack); end
        tick();
        sb_dequeue_ready = 0;
        checks++; if ({l2_req_valid, l2_req_op, l2_req_id, l2_req_addr, l2_req_mask} !== {1'b1, 2'd3, 2'd3, 32'h0000_3080, 64'h1}) begin failures++; $display("FAIL bp_next_pkt valid=%b op=%0d id=%0d addr=%h exp_addr=00003080", l2_req_valid, l2_req_op, l2_req_id, l2_req_addr); end
    endtask

    task automatic test_sc_response();
        do_reset();
        l2_rsp_valid = 1; l2_rsp_core = CORE_ID_V; l2_rsp_op = 2'd3; l2_rsp_id = 2'd1; l2_rsp_status = 1;
        tick();
        l2_rsp_valid = 0;
        checks++; if ({storebuf_l2_response_valid, storebuf_l2_response_idx, storebuf_l2_sync_success, fill_valid} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin failures++; $display("FAIL sc_rsp got=%b exp=10110", {storebuf_l2_response_valid, storebuf_l2_response_idx, storebuf_l2_sync_success, fill_valid}); end
        tick();
        checks++; if (storebuf_l2_response_valid !== 1'b0) begin failures++; $display("FAIL sc_rsp_one_cycle got=%b exp=0", storebuf_l2_response_valid); end
    endtask

    task automatic test_foreign_core();
        logic [DW-1:0] d;
        do_reset();
        d = rand_line();
        l2_rsp_valid = 1; l2_rsp_core = CORE_ID_V + 1'b1; l2_rsp_op = 2'd0; l2_rsp_id = 2'd3; l2_rsp_data = d;
        tick();
        checks++; if ({fill_valid, storebuf_l2_response_valid} !== 2'b00) begin failures++; $display("FAIL foreign_ignored got=%b exp=00", {fill_valid, storebuf_l2_response_valid}); end
        l2_rsp_core = CORE_ID_V;
        tick();
        l2_rsp_valid = 0;
        checks++; if ({fill_valid, fill_idx, fill_sync, storebuf_l2_response_valid} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin failures++; $display("FAIL own_fill got=%b exp=11100", {fill_valid, fill_idx, fill_sync, storebuf_l2_response_valid}); end
        checks++; if (fill_data !== d) begin failures++; $display("FAIL own_fill_data got=%h exp=%h", fill_data, d); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sb_dequeue_ready = 1; sb_dequeue_addr = 32'h4000; sb_dequeue_idx = 2'd0; sb_dequeue_mask = '1;
        l2_req_ready = 0;
        settle();
        tick();
        sb_dequeue_ready = 0;
        checks++; if (l2_req_valid !== 1'b1) begin failures++; $display("FAIL mid_held got=%b exp=1", l2_req_valid); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (l2_req_valid !== 1'b0) begin failures++; $display("FAIL mid_async_drop got=%b exp=0", l2_req_valid); end
        zero_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        sb_dequeue_ready = 1; lm_dequeue_ready = 1; l2_req_ready = 1;
        settle();
        checks++; if ({sb_dequeue_ack, lm_dequeue_ack} !== 2'b10) begin failures++; $display("FAIL mid_rr_store_first got=%b exp=10", {sb_dequeue_ack, lm_dequeue_ack}); end
        tick();
    endtask

    task automatic test_random();
        logic sb_pend, lm_pend;
        do_reset();
        sb_pend = 0;
        lm_pend = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!sb_pend) begin
                sb_dequeue_ready = ($urandom_range(0, 2) != 0);
                sb_dequeue_addr = {$urandom_range(0, 65535), 6'd0}; sb_dequeue_idx = 2'($urandom);
                sb_dequeue_mask = rand_mask(); sb_dequeue_data = rand_line();
                sb_dequeue_synchronized = 1'($urandom);
            end
            if (!lm_pend) begin
                lm_dequeue_ready = ($urandom_range(0, 2) != 0);
                lm_dequeue_addr = {$urandom_range(0, 65535), 6'd0}; lm_dequeue_idx = 2'($urandom);
                lm_dequeue_synchronized = 1'($urandom);
            end
            l2_req_ready = ($urandom_range(0, 3) != 0);
            l2_rsp_valid = 1'($urandom); l2_rsp_core = 2'($urandom_range(0, 1));
            l2_rsp_op = 2'($urandom); l2_rsp_id = 2'($urandom); l2_rsp_status = 1'($urandom);
            l2_rsp_data = rand_line();
            settle();
            checks++; if ({sb_dequeue_ack, lm_dequeue_ack} !== {e_sb_ack, e_lm_ack}) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", cyc, {sb_dequeue_ack, lm_dequeue_ack}, {e_sb_ack, e_lm_ack}); end
            sb_pend = sb_dequeue_ready && !e_sb_ack;
            lm_pend = lm_dequeue_ready && !e_lm_ack;
            tick();
            checks++; if (l2_req_valid !== (exp_q.size() != 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, l2_req_valid, exp_q.size() != 0); end
            if (exp_q.size() != 0) begin
                checks++; if ({l2_req_op, l2_req_core, l2_req_id, l2_req_addr, l2_req_mask, l2_req_data} !== exp_q[0]) begin failures++; $display("FAIL rnd_pkt cyc=%0d got_op=%0d got_id=%0d got_addr=%h exp_pkt_hi=%h", cyc, l2_req_op, l2_req_id, l2_req_addr, exp_q[0][PW-1 -: 38]); end
            end
            checks++; if ({storebuf_l2_response_valid, fill_valid} !== {m_sbv, m_fv}) begin failures++; $display("FAIL rnd_rsp_valid cyc=%0d got=%b exp=%b", cyc, {storebuf_l2_response_valid, fill_valid}, {m_sbv, m_fv}); end
            if (m_sbv) begin
                checks++; if ({storebuf_l2_response_idx, storebuf_l2_sync_success} !== {m_sbidx, m_sbss}) begin failures++; $display("FAIL rnd_sb_rsp cyc=%0d got=%b exp=%b", cyc, {storebuf_l2_response_idx, storebuf_l2_sync_success}, {m_sbidx, m_sbss}); end
            end
            if (m_fv) begin
                checks++; if ({fill_idx, fill_sync, fill_data} !== {m_fidx, m_fsync, m_fdata}) begin failures++; $display("FAIL rnd_fill cyc=%0d got_idx=%0d got_sync=%b exp_idx=%0d exp_sync=%b", cyc, fill_idx, fill_sync, m_fidx, m_fsync); end
            end
        end
    endtask

    initial begin
        zero_inputs();
        model_reset();
        test_reset();
        test_store_only();
        test_back_to_back();
        test_backpressure();
        test_sc_response();
        test_foreign_core();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
